bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: value driven on bit_out when no word is being shifted.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 bit_out  output  1  serial bit stream; feeds the din input of the downstream sequence detector.
REQ-009 bit_valid  output  1  bit_out carries a data bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse on the last bit of each word.
REQ-011 busy  output  1  shifter or hold register occupied.

Function
REQ-012 Internal state SHALL be: shift register sr (WIDTH), bit counter cnt (0..WIDTH-1), one-entry hold register hd with flag hd_full, and FSM state in {IDLE, SHIFT}.
REQ-013 A word SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1; in_ready SHALL equal !hd_full, registered-state only, with no combinational path from in_valid.
REQ-014 A load event SHALL occur on an edge where state=IDLE, or where state=SHIFT and cnt=WIDTH-1.
REQ-015 On a load event: if hd_full, sr<=hd, hd_full<=0. Otherwise, if a word is accepted on that edge, sr<=in_data (bypass; hd untouched). Otherwise the FSM SHALL go to IDLE.
REQ-016 When sr loads, state<=SHIFT and cnt<=0. In SHIFT without a load event, cnt SHALL increment and sr SHALL shift by one toward the output bit.
REQ-017 An accepted word not consumed by bypass SHALL be written to hd, setting hd_full=1.
REQ-018 Latency: a word accepted in IDLE at edge N SHALL present its first bit during the cycle following edge N. All WIDTH bits SHALL appear on consecutive cycles.
REQ-019 Back-to-back words (hd_full at the last bit) SHALL stream with zero gap cycles.
REQ-020 bit_valid SHALL be 1 exactly when state=SHIFT; bit_out SHALL be the output bit of sr in SHIFT, else IDLE_LEVEL.
REQ-021 word_done SHALL be 1 exactly when state=SHIFT and cnt=WIDTH-1.
REQ-022 busy SHALL be (state=SHIFT) OR hd_full.
REQ-023 When hd_full=1, in_valid SHALL be ignored. A word offered while hd drains on the same edge SHALL NOT be accepted until the next cycle.
REQ-024 All outputs SHALL be driven from registers or from decode of registered state only.

Reset
REQ-025 While reset=1: state=IDLE, cnt=0, sr=0, hd=0, hd_full=0. Outputs: bit_out=IDLE_LEVEL, bit_valid=0, word_done=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-word SHALL discard the partial word and any held word, with no trailing bits emitted after release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro SERIALIZER_LSB_FIRST_EN: when defined, bits SHALL be emitted LSB first (sr shifts right, output is sr[0]).
REQ-029 When SERIALIZER_LSB_FIRST_EN is undefined, bits SHALL be emitted MSB first (sr shifts left, output is sr[WIDTH-1]). All other behaviour SHALL be identical.

Verification (WIDTH=8, IDLE_LEVEL=0, MSB first unless noted)
REQ-030 Single word: accept 8'hD0 in IDLE -> next 8 cycles bit_out=1,1,0,1,0,0,0,0 with bit_valid=1 and word_done on cycle 8. Then bit_valid=0, bit_out=0, busy=0.
REQ-031 Back-to-back: offer 8'hD0 then 8'hDD one cycle later -> 16 contiguous valid bits 11010000_11011101, word_done on cycles 8 and 16, no gap.
REQ-032 Backpressure: in_valid held high with 3 distinct words -> words 1 and 2 accepted, in_ready=0 until the edge of word 1's last bit, word 3 accepted on the following edge, all 24 bits in order.
REQ-033 Reset mid-word: assert reset after 3 bits of 8'hFF -> bit_out=0, bit_valid=0, busy=0, in_ready=1 immediately. After release, no residual bits appear.
REQ-034 SERIALIZER_LSB_FIRST_EN defined: accept 8'h0B -> bit_out=1,1,0,1,0,0,0,0 with word_done on the 8th bit.
REQ-035 Idle stream: no in_valid for 20 cycles after reset -> bit_out=IDLE_LEVEL, bit_valid=0, word_done=0 throughout.

Source files
------------

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial shifter with one-entry hold register
// Define SERIALIZER_LSB_FIRST_EN for LSB-first emission; MSB-first otherwise.
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hd_q, hd_d;
    logic             hd_full_q, hd_full_d;

    logic accept;
    logic load_evt;
    logic out_bit;

    assign accept   = in_valid && !hd_full_q;
    assign load_evt = (state_q == IDLE) || (cnt_q == CNT_LAST);

`ifdef SERIALIZER_LSB_FIRST_EN
    assign out_bit = sr_q[0];
`else
    assign out_bit = sr_q[WIDTH-1];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        hd_d      = hd_q;
        hd_full_d = hd_full_q;

        if (load_evt) begin
            // Held word has priority; a new offer waits until the hold slot frees.
            if (hd_full_q) begin
                sr_d      = hd_q;
                hd_full_d = 1'b0;
                state_d   = SHIFT;
                cnt_d     = '0;
            end else if (accept) begin
                sr_d    = in_data;
                state_d = SHIFT;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIALIZER_LSB_FIRST_EN
            sr_d  = sr_q >> 1;
`else
            sr_d  = sr_q << 1;
`endif
            if (accept) begin
                hd_d      = in_data;
                hd_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            hd_q      <= '0;
            hd_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            hd_q      <= hd_d;
            hd_full_q <= hd_full_d;
        end
    end

    assign in_ready  = !hd_full_q;
    assign bit_valid = (state_q == SHIFT);
    assign bit_out   = (state_q == SHIFT) ? out_bit : IDLE_LEVEL;
    assign word_done = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign busy      = (state_q == SHIFT) || hd_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - vector table, directed corners and random run against a bit-queue model
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         word_done;
    logic         busy;

    int tests = 0;
    int fails = 0;

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

`ifdef SERIALIZER_LSB_FIRST_EN
    localparam logic [W-1:0] WORD_A = 8'h0B;
    localparam logic [W-1:0] WORD_B = 8'hBB;
`else
    localparam logic [W-1:0] WORD_A = 8'hD0;
    localparam logic [W-1:0] WORD_B = 8'hDD;
`endif

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         bo, bv, wd, bsy, rdy;
    } vec_t;

    vec_t vecs[18];

    // Reference: the bits still to be emitted by the word on the wire, plus the held word.
    bit           cur_q[$];
    bit           held;
    logic [W-1:0] hold_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_load(input logic [W-1:0] w);
        cur_q.delete();
        for (int i = 0; i < W; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            cur_q.push_back(w[i]);
`else
            cur_q.push_back(w[W-1-i]);
`endif
        end
    endfunction

    function automatic void model_clear();
        cur_q.delete();
        held   = 1'b0;
        hold_w = '0;
    endfunction

    // Called at a negedge: check outputs against the model, drive, advance one edge.
    task automatic cycle_model(input logic v, input logic [W-1:0] d);
        bit acc;
        chk("m_bit_valid", 32'(bit_valid), 32'(cur_q.size() > 0));
        chk("m_bit_out",   32'(bit_out),   (cur_q.size() > 0) ? 32'(cur_q[0]) : 32'd0);
        chk("m_word_done", 32'(word_done), 32'(cur_q.size() == 1));
        chk("m_busy",      32'(busy),      32'((cur_q.size() > 0) || held));
        chk("m_in_ready",  32'(in_ready),  32'(!held));
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = v && !held;
        if (cur_q.size() <= 1) begin
            if (held) begin
                model_load(hold_w);
                held = 1'b0;
            end else if (acc) begin
                model_load(d);
            end else begin
                cur_q.delete();
            end
        end else begin
            void'(cur_q.pop_front());
            if (acc) begin
                hold_w = d;
                held   = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] words[3];
        int           widx;

        // Back-to-back pair; the second word waits in the hold register.
        vecs[0]  = '{1'b1, WORD_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, WORD_B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'h00,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_bit_out",   32'(bit_out),   32'd0);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_word_done", 32'(word_done), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;

        // First vector offers a word on the very first edge after release.
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_bit_out", i),   32'(bit_out),   32'(vecs[i].bo));
            chk($sformatf("vec%0d_bit_valid", i), 32'(bit_valid), 32'(vecs[i].bv));
            chk($sformatf("vec%0d_word_done", i), 32'(word_done), 32'(vecs[i].wd));
            chk($sformatf("vec%0d_busy", i),      32'(busy),      32'(vecs[i].bsy));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].rdy));
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            @(posedge clk);
            @(negedge clk);
        end

        // Idle stream.
        for (int i = 0; i < 20; i++) cycle_model(1'b0, 8'h00);

        // Backpressure: in_valid held high, each word offered until the model accepts it.
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hE1;
        widx = 0;
        for (int c = 0; c < 40; c++) begin
            if (widx < 3) begin
                bit will_take;
                will_take = !held;
                cycle_model(1'b1, words[widx]);
                if (will_take) widx++;
            end else begin
                cycle_model(1'b0, 8'h00);
            end
        end
        chk("bp_all_accepted", 32'(widx), 32'd3);

        // Reset mid-word with a word also waiting in the hold register.
        cycle_model(1'b1, 8'hFF);
        cycle_model(1'b1, 8'hAA);
        cycle_model(1'b0, 8'h00);
        reset = 1'b1;
        #1;
        chk("mid_rst_bit_out",   32'(bit_out),   32'd0);
        chk("mid_rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) cycle_model(1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle_model(1'($urandom_range(0, 1)), W'($urandom));
        end
        for (int i = 0; i < 20; i++) cycle_model(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
